// File: rtl/bf_io_bridge.sv
// Byte I/O bridge between the cpu byte bus and a host valid/ready stream.
// Host->cpu input FIFO and cpu->host output FIFO (show-ahead), with drop accounting on output.
module bf_io_bridge #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned IN_DEPTH_LOG2  = 4,
    parameter int unsigned OUT_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     host_in_data,
    input  logic                      host_in_valid,
    output logic                      host_in_ready,
    output logic [DATA_WIDTH-1:0]     cpu_data_in,
    output logic                      cpu_data_available,
    input  logic                      cpu_data_read,
    input  logic [DATA_WIDTH-1:0]     cpu_data_out,
    input  logic                      cpu_data_out_en,
    output logic [DATA_WIDTH-1:0]     host_out_data,
    output logic                      host_out_valid,
    input  logic                      host_out_ready,
    output logic [IN_DEPTH_LOG2:0]    in_level,
    output logic [OUT_DEPTH_LOG2:0]   out_level,
    output logic                      out_overflow,
    output logic [7:0]                drop_count,
    input  logic                      overflow_clear
);

    localparam int unsigned IN_PW     = IN_DEPTH_LOG2 + 1;
    localparam int unsigned OUT_PW    = OUT_DEPTH_LOG2 + 1;
    localparam int unsigned IN_DEPTH  = 1 << IN_DEPTH_LOG2;
    localparam int unsigned OUT_DEPTH = 1 << OUT_DEPTH_LOG2;

    // ---------------- input FIFO (host -> cpu) ----------------
    logic [DATA_WIDTH-1:0] in_mem [IN_DEPTH];
    logic [IN_PW-1:0]      in_wr;
    logic [IN_PW-1:0]      in_rd;
    logic                  in_full;
    logic                  in_empty;
    logic                  in_push;
    logic                  in_pop;

    always_comb begin
        in_level           = in_wr - in_rd;
        in_full            = (in_level == IN_PW'(IN_DEPTH));
        in_empty           = (in_level == '0);
        host_in_ready      = !rst && !in_full;
        in_push            = host_in_valid && host_in_ready;
        cpu_data_available = !in_empty;
        in_pop             = !rst && cpu_data_read && !in_empty;
        cpu_data_in        = in_empty ? '0 : in_mem[in_rd[IN_DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr <= '0;
            in_rd <= '0;
        end else begin
            if (in_push)
                in_wr <= in_wr + IN_PW'(1);
            if (in_pop)
                in_rd <= in_rd + IN_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr[IN_DEPTH_LOG2-1:0]] <= host_in_data;
    end

    // ---------------- output FIFO (cpu -> host) ----------------
    logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [OUT_PW-1:0]     out_wr;
    logic [OUT_PW-1:0]     out_rd;
    logic                  out_full;
    logic                  out_empty;
    logic                  out_drain;
    logic                  out_capture;
    logic                  out_drop;

    // A drain in the same cycle frees the slot the capture writes into.
    always_comb begin
        out_level      = out_wr - out_rd;
        out_full       = (out_level == OUT_PW'(OUT_DEPTH));
        out_empty      = (out_level == '0);
        host_out_valid = !out_empty;
        host_out_data  = out_empty ? '0 : out_mem[out_rd[OUT_DEPTH_LOG2-1:0]];
        out_drain      = !rst && host_out_valid && host_out_ready;
        out_capture    = !rst && cpu_data_out_en && (!out_full || out_drain);
        out_drop       = !rst && cpu_data_out_en && !out_capture;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr <= '0;
            out_rd <= '0;
        end else begin
            if (out_capture)
                out_wr <= out_wr + OUT_PW'(1);
            if (out_drain)
                out_rd <= out_rd + OUT_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (out_capture)
            out_mem[out_wr[OUT_DEPTH_LOG2-1:0]] <= cpu_data_out;
    end

    // A drop coinciding with overflow_clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_overflow <= 1'b0;
            drop_count   <= '0;
        end else if (out_drop) begin
            out_overflow <= 1'b1;
            if (overflow_clear)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (overflow_clear) begin
            out_overflow <= 1'b0;
            drop_count   <= '0;
        end
    end

endmodule
